// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer.
// PC-source select codes and the redirect FSM state codes.
package pipe_ctrl_pkg;

    localparam logic [1:0] PCSEL_NPC = 2'b00;
    localparam logic [1:0] PCSEL_EXC = 2'b01;
    localparam logic [1:0] PCSEL_EPC = 2'b10;

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_REDIRECT = 1'b1;

endpackage

// File: rtl/md_busy_counter.sv
// Multiply/divide busy counter: loads the op latency on issue, counts down.
// Ports: Clk, Reset, hold (redirect freeze), start, div -> cnt, busy.
module md_busy_counter #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       hold,
    input  logic       start,
    input  logic       div,
    output logic [3:0] cnt,
    output logic       busy
);

    localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);

    assign busy = (cnt != 4'd0);

    // A start while busy is ignored; the count just keeps running down.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt <= 4'd0;
        end else if (hold) begin
            cnt <= cnt;
        end else if (start && !busy) begin
            cnt <= div ? DIV_LD : MULT_LD;
        end else if (busy) begin
            cnt <= cnt - 4'd1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush/redirect sequencer for the 5-stage pipeline.
// In: hazard, MD use/start, exception/eret; out: PC, D/E/M ctrl, MD busy, stall count.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        LoadUseHazD,
    input  logic        MDUseD,
    input  logic        MDStartE,
    input  logic        MDDivE,
    input  logic        ExcReqM,
    input  logic        EretM,
    output logic        PCEn,
    output logic [1:0]  PCSel,
    output logic        DRegEn,
    output logic        DRegFlush,
    output logic        ERegFlush,
    output logic        MRegFlush,
    output logic        MDBusy,
    output logic [3:0]  MDCnt,
    output logic [31:0] StallCnt
);

    logic [0:0]  state;
    logic        redirect;
    logic        stall;
    logic [31:0] stall_cnt;

    md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md (
        .Clk   (Clk),
        .Reset (Reset),
        .hold  (redirect),
        .start (MDStartE),
        .div   (MDDivE),
        .cnt   (MDCnt),
        .busy  (MDBusy)
    );

    // The cycle after a redirect M holds a bubble, so exc/eret are ignored.
    assign redirect = (ExcReqM | EretM) && (state == ST_RUN);
    assign stall    = !redirect &&
                      (LoadUseHazD | (MDUseD & (MDBusy | MDStartE)));

    always_comb begin
        PCEn      = 1'b1;
        PCSel     = PCSEL_NPC;
        DRegEn    = 1'b1;
        DRegFlush = 1'b0;
        ERegFlush = 1'b0;
        MRegFlush = 1'b0;
        priority case (1'b1)
            Reset: begin
                PCEn      = 1'b0;
                DRegEn    = 1'b0;
                DRegFlush = 1'b1;
                ERegFlush = 1'b1;
                MRegFlush = 1'b1;
            end
            redirect: begin
                PCSel     = ExcReqM ? PCSEL_EXC : PCSEL_EPC;
                DRegFlush = 1'b1;
                ERegFlush = 1'b1;
                MRegFlush = 1'b1;
            end
            stall: begin
                PCEn      = 1'b0;
                DRegEn    = 1'b0;
                ERegFlush = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= ST_RUN;
        end else begin
            state <= redirect ? ST_REDIRECT : ST_RUN;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stall_cnt <= 32'd0;
        end else if (stall) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign StallCnt = stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized + directed bench for pipe_hazard_ctrl against a behavioural model.
// Model tracks remaining MD cycles, redirect shadow and stall count.
module tb_pipe_hazard_ctrl;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        LoadUseHazD = 1'b0;
    logic        MDUseD = 1'b0;
    logic        MDStartE = 1'b0;
    logic        MDDivE = 1'b0;
    logic        ExcReqM = 1'b0;
    logic        EretM = 1'b0;
    logic        PCEn;
    logic [1:0]  PCSel;
    logic        DRegEn;
    logic        DRegFlush;
    logic        ERegFlush;
    logic        MRegFlush;
    logic        MDBusy;
    logic [3:0]  MDCnt;
    logic [31:0] StallCnt;

    pipe_hazard_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .LoadUseHazD (LoadUseHazD),
        .MDUseD      (MDUseD),
        .MDStartE    (MDStartE),
        .MDDivE      (MDDivE),
        .ExcReqM     (ExcReqM),
        .EretM       (EretM),
        .PCEn        (PCEn),
        .PCSel       (PCSel),
        .DRegEn      (DRegEn),
        .DRegFlush   (DRegFlush),
        .ERegFlush   (ERegFlush),
        .MRegFlush   (MRegFlush),
        .MDBusy      (MDBusy),
        .MDCnt       (MDCnt),
        .StallCnt    (StallCnt)
    );

    always #5 Clk = ~Clk;

    int          n_tests = 0;
    int          n_fail = 0;
    int          md_left = 0;
    bit          after_redir = 1'b0;
    logic [31:0] stall_ref = 32'd0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        #2 Reset = 1'b1;
        #1;
        check("rst_pcen", PCEn, 0);
        check("rst_dregen", DRegEn, 0);
        check("rst_dflush", DRegFlush, 1);
        check("rst_eflush", ERegFlush, 1);
        check("rst_mflush", MRegFlush, 1);
        check("rst_pcsel", PCSel, 0);
        check("rst_busy", MDBusy, 0);
        check("rst_mdcnt", MDCnt, 0);
        check("rst_stallcnt", StallCnt, 0);
        md_left = 0;
        after_redir = 1'b0;
        stall_ref = 32'd0;
        @(posedge Clk);
        #1 Reset = 1'b0;
    endtask

    task automatic cycle(input bit lu, input bit mu, input bit st,
                         input bit dv, input bit ex, input bit er);
        bit busy, redir, stl;
        logic [1:0] sel;
        LoadUseHazD = lu;
        MDUseD = mu;
        MDStartE = st;
        MDDivE = dv;
        ExcReqM = ex;
        EretM = er;
        #1;
        busy = (md_left > 0);
        redir = (ex || er) && !after_redir;
        stl = !redir && (lu || (mu && (busy || st)));
        sel = !redir ? 2'b00 : (ex ? 2'b01 : 2'b10);
        check("pcen", PCEn, redir || !stl);
        check("dregen", DRegEn, !stl);
        check("dflush", DRegFlush, redir);
        check("eflush", ERegFlush, redir || stl);
        check("mflush", MRegFlush, redir);
        check("pcsel", PCSel, sel);
        check("busy", MDBusy, busy);
        check("mdcnt", MDCnt, md_left);
        check("stallcnt", StallCnt, stall_ref);
        @(posedge Clk);
        if (!redir) begin
            if (st && !busy) md_left = dv ? 10 : 5;
            else if (md_left > 0) md_left--;
        end
        if (stl) stall_ref = stall_ref + 32'd1;
        after_redir = redir;
        #1;
    endtask

    initial begin
        logic [31:0] snap;
        #3 do_reset();

        cycle(1, 0, 0, 0, 0, 0);
        check("lu_stallcnt", StallCnt, 1);
        cycle(0, 0, 0, 0, 0, 0);

        do_reset();
        cycle(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 0, 0);
        check("mult_mdcnt0", MDCnt, 0);
        check("mult_stall6", StallCnt, 6);
        cycle(0, 1, 0, 0, 0, 0);

        cycle(0, 0, 1, 1, 1, 0);
        check("exc_mdcnt", MDCnt, 0);
        cycle(0, 0, 0, 0, 1, 0);

        snap = stall_ref;
        cycle(1, 0, 0, 0, 1, 1);
        check("exc_eret_nostall", StallCnt, snap);
        cycle(0, 0, 0, 0, 0, 0);

        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);

        cycle(0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0);
        check("mdcnt7", MDCnt, 7);
        do_reset();

        force dut.stall_cnt = 32'hFFFF_FFFF;
        #1 release dut.stall_cnt;
        stall_ref = 32'hFFFF_FFFF;
        cycle(1, 0, 0, 0, 0, 0);
        check("wrap", StallCnt, 0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 3) == 0,
                      $urandom_range(0, 1) == 0,
                      $urandom_range(0, 2) == 0,
                      $urandom_range(0, 1) == 0,
                      $urandom_range(0, 9) == 0,
                      $urandom_range(0, 9) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives enable and flush of the D register, and flush of the E/M registers.
- Also drives PC enable and the PC-source select.
- Owns the multiply/divide busy counter, the exception/eret redirect sequence and a stall performance counter.
- Sits between the hazard-compare logic, the CP0/exception logic (M stage) and the pipeline registers.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu after issue in E (1..15).
- DIV_CYCLES, 10, busy cycles for div/divu after issue in E (1..15).

Ports:
- Clk  in  1  clock, rising-edge.
- Reset  in  1  asynchronous, active-high reset.
- LoadUseHazD  in  1  D-stage instruction needs a load result still in E/M (from hazard compare).
- MDUseD  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
- MDStartE  in  1  mult/div instruction valid in E this cycle.
- MDDivE  in  1  with MDStartE: 1 = div/divu, 0 = mult/multu.
- ExcReqM  in  1  exception or interrupt taken at M this cycle.
- EretM  in  1  eret at M this cycle.
- PCEn  out  1  PC register update enable.
- PCSel  out  2  00 sequential/branch, 01 exception entry, 10 EPC.
- DRegEn  out  1  D register enable.
- DRegFlush  out  1  D register flush.
- ERegFlush  out  1  E register flush (bubble insert).
- MRegFlush  out  1  M register flush.
- MDBusy  out  1  mult/div unit busy.
- MDCnt  out  4  remaining busy cycles.
- StallCnt  out  32  cycles spent stalled since reset.

Behaviour:
- Registered state: MDCnt[3:0], StallCnt[31:0], and a 1-bit FSM with states RUN and REDIRECT. All clear asynchronously on Reset; the FSM resets to RUN.
- While Reset is high, the combinational outputs are: PCEn=0, DRegEn=0, DRegFlush=ERegFlush=MRegFlush=1, PCSel=00. MDBusy=0.
- MDBusy = (MDCnt != 0).
- Redirect = (ExcReqM | EretM) and state==RUN.
- ExcReqM and EretM together: ExcReqM wins, PCSel=01.
- Redirect cycle:
  - PCEn=1, PCSel=01 (exception) or 10 (eret).
  - DRegFlush=ERegFlush=MRegFlush=1, DRegEn=1.
  - Stall is ignored.
  - Next state is REDIRECT.
- REDIRECT state: lasts exactly 1 cycle, then returns to RUN.
  - ExcReqM/EretM are ignored; M holds a bubble.
  - Outputs follow the normal rules below.
- Stall = LoadUseHazD | (MDUseD & (MDBusy | MDStartE)). It is evaluated only when not Redirect.
- Stall cycle: PCEn=0, DRegEn=0, DRegFlush=0, ERegFlush=1, MRegFlush=0, PCSel=00.
- Normal cycle (no stall): PCEn=1, DRegEn=1, all flushes 0, PCSel=00.
- MD counter, next-cycle value:
  - Redirect: MDCnt unchanged. A start in the same cycle is suppressed because the E instruction is flushed.
  - Else if MDStartE and !MDBusy: load DIV_CYCLES if MDDivE, otherwise MULT_CYCLES.
  - Else if MDStartE and MDBusy: protocol violation. Counter keeps decrementing and the start is ignored. Stall logic prevents this case.
  - Else if MDCnt != 0: decrement by 1. It never goes below 0.
  - A start in cycle t gives MDBusy=1 for cycles t+1 .. t+N. D-stage MD use stalls in cycles t .. t+N.
- StallCnt increments by 1 on each rising edge whose cycle was a stall cycle (Stall & !Redirect), and wraps at 2^32.

Decomposition:
- Shared package pipe_ctrl_pkg: PCSel encodings PCSEL_NPC=2'b00, PCSEL_EXC=2'b01, PCSEL_EPC=2'b10; FSM state encodings RUN/REDIRECT.
- One sub-module is natural: md_busy_counter, covering the MDCnt load/decrement and MDBusy.
- Stall/redirect decode and StallCnt stay in the top module.

Test Plan:
- Reset asserted mid-run with MDCnt=7 -> MDCnt=0, StallCnt=0 immediately (asynchronous). While Reset is high, PCEn=0 and all flushes=1.
- LoadUseHazD=1 for one cycle -> that cycle has PCEn=0, DRegEn=0, ERegFlush=1. StallCnt goes 0->1. The next cycle is a normal cycle.
- MDStartE=1, MDDivE=0 at cycle 0, with MDUseD=1 from cycle 0 -> stall in cycles 0..5. MDCnt reads 5,4,3,2,1 over cycles 1..5, then 0 at cycle 6; release at cycle 6. StallCnt=6.
- MDStartE=1, MDDivE=1 together with ExcReqM=1 -> MDCnt stays 0. PCSel=01, PCEn=1, D/E/M flushes=1. The next cycle is REDIRECT, and ExcReqM=1 there is ignored (PCSel=00).
- ExcReqM=1 and EretM=1 together, with LoadUseHazD=1 -> PCSel=01, PCEn=1, no stall counted (StallCnt unchanged).
- EretM=1 alone in RUN -> PCSel=10 for one cycle, then REDIRECT, then RUN. StallCnt preloaded near 2^32-1 plus a stall -> StallCnt wraps to 0.
